// File: rtl/aznable_pkg.sv
// -----------------------------------------------------------------------------
// aznable_pkg
// Shared definitions for the ioctl upload (save) path.
//   state_t     : responder FSM states
//   PAD_DEFAULT : byte returned for reads beyond the valid save region
// -----------------------------------------------------------------------------
package aznable_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      ARMED,
      FETCH,
      DONE
   } state_t;

   localparam logic [7:0] PAD_DEFAULT = 8'hFF;

endpackage : aznable_pkg

// File: rtl/ioctl_upload_responder.sv
// -----------------------------------------------------------------------------
// ioctl_upload_responder
// Core-side responder for the HPS ioctl upload (save) path. Serves bytes from
// the save RAM to hps_io on each ioctl_rd, tracks a dirty flag from CPU writes
// and asks the HPS for an upload on save_req.
//
// Ports
//   clk_sys, reset_n   : system clock, asynchronous active-low reset
//   save_req           : 1-cycle request to upload the save RAM
//   cpu_wr             : CPU write strobe into the save region (sets dirty)
//   ioctl_upload       : hps_io upload active
//   ioctl_index        : hps_io current index
//   ioctl_rd           : hps_io read strobe (1 cycle)
//   ioctl_addr         : hps_io byte address
//   ioctl_din          : byte returned to hps_io (holds between reads)
//   ioctl_wait         : stall to hps_io while a byte is being fetched
//   ioctl_upload_req   : 1-cycle upload request pulse to hps_io
//   mem_addr, mem_rd   : save RAM read port request
//   mem_data           : save RAM read data, MEM_LATENCY cycles after mem_rd
//   dirty              : save RAM modified since the last completed upload
//   busy               : FSM not idle (system pauses the CPU on it)
// -----------------------------------------------------------------------------
module ioctl_upload_responder
   import aznable_pkg::*;
#(
   parameter logic [7:0]  INDEX       = 8'd5,
   parameter int          AW          = 13,
   parameter int          SIZE        = 8192,
   parameter int          MEM_LATENCY = 1,
   parameter logic [7:0]  PAD         = PAD_DEFAULT,
   parameter logic [23:0] TIMEOUT     = 24'd2400000
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          save_req,
   input  logic          cpu_wr,
   input  logic          ioctl_upload,
   input  logic [7:0]    ioctl_index,
   input  logic          ioctl_rd,
   input  logic [24:0]   ioctl_addr,
   output logic [7:0]    ioctl_din,
   output logic          ioctl_wait,
   output logic          ioctl_upload_req,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd,
   input  logic [7:0]    mem_data,
   output logic          dirty,
   output logic          busy
);

   localparam logic [31:0] SIZE_U   = 32'(SIZE);
   localparam logic [1:0]  LAT_LAST = 2'(MEM_LATENCY - 1);

   state_t      state, state_nx;
   logic [23:0] timer;
   logic [1:0]  lat_cnt;
   logic        wr_during;

   logic hit;
   logic in_range;
   logic rd_ok;
   logic fetch_go;
   logic pad_go;
   logic fetch_done;
   logic armed_entry;

   assign hit        = ioctl_upload && (ioctl_index == INDEX);
   assign in_range   = {7'd0, ioctl_addr} < SIZE_U;
   // Reads only count while armed; a stray ioctl_rd in any other state (or on
   // another index) must not stall hps_io or touch the RAM.
   assign rd_ok      = (state == ARMED) && ioctl_rd && hit;
   assign fetch_go   = rd_ok && in_range;
   assign pad_go     = rd_ok && !in_range;
   assign fetch_done = (state == FETCH) && (lat_cnt == LAT_LAST);

   // The RAM request is issued combinationally in the ioctl_rd cycle so the
   // byte is captured MEM_LATENCY cycles later, giving MEM_LATENCY+1 total.
   assign mem_rd     = fetch_go;
   assign mem_addr   = fetch_go ? ioctl_addr[AW-1:0] : '0;
   assign ioctl_wait = fetch_go || (state == FETCH);
   assign busy       = (state != IDLE);

   // Upload session start: wr_during restarts here, not on FETCH -> ARMED.
   assign armed_entry = (state_nx == ARMED) && ((state == IDLE) || (state == REQ));

   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            // An HPS-initiated upload takes priority over a local request.
            if (hit)           state_nx = ARMED;
            else if (save_req) state_nx = REQ;
         end
         REQ: begin
            if (hit)                             state_nx = ARMED;
            else if (timer == TIMEOUT - 24'd1)   state_nx = IDLE;
         end
         ARMED: begin
            if (!hit)          state_nx = DONE;
            else if (fetch_go) state_nx = FETCH;
         end
         FETCH: begin
            // An abort mid-fetch still completes the fetch before DONE.
            if (fetch_done)    state_nx = hit ? ARMED : DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         timer            <= '0;
         lat_cnt          <= '0;
         wr_during        <= 1'b0;
         dirty            <= 1'b0;
         ioctl_din        <= '0;
         ioctl_upload_req <= 1'b0;
      end else begin
         state            <= state_nx;
         ioctl_upload_req <= (state == IDLE) && (state_nx == REQ);

         if ((state == REQ) && (state_nx == REQ)) timer <= timer + 24'd1;
         else                                     timer <= '0;

         if ((state == FETCH) && !fetch_done) lat_cnt <= lat_cnt + 2'd1;
         else                                 lat_cnt <= '0;

         if (fetch_done)  ioctl_din <= mem_data;
         else if (pad_go) ioctl_din <= PAD;

         if (armed_entry)          wr_during <= 1'b0;
         else if (busy && cpu_wr)  wr_during <= 1'b1;

         // A write that landed during the upload (or in DONE itself) means
         // the saved image is stale, so dirty survives.
         if (state == DONE) dirty <= cpu_wr || wr_during;
         else if (cpu_wr)   dirty <= 1'b1;
      end
   end

endmodule : ioctl_upload_responder

// File: tb/tb_ioctl_upload_responder.sv
// -----------------------------------------------------------------------------
// tb_ioctl_upload_responder
// Directed sequence with randomized RAM contents and addresses. A byte-array
// RAM with MEM_LATENCY read pipeline stands in for the save RAM; expected
// bytes, wait lengths and the dirty flag come from a session-level model.
// -----------------------------------------------------------------------------
module tb_ioctl_upload_responder;

   localparam int          L       = 2;
   localparam int          SIZE    = 8192;
   localparam logic [23:0] TMO     = 24'd100;
   localparam logic [7:0]  IDX     = 8'd5;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        save_req, cpu_wr, ioctl_upload, ioctl_rd;
   logic [7:0]  ioctl_index;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait, ioctl_upload_req;
   logic [12:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_data;
   logic        dirty, busy;

   always #5 clk_sys = ~clk_sys;

   ioctl_upload_responder #(
      .INDEX(IDX), .AW(13), .SIZE(SIZE), .MEM_LATENCY(L),
      .PAD(8'hFF), .TIMEOUT(TMO)
   ) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .save_req(save_req), .cpu_wr(cpu_wr),
      .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd),
      .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
      .ioctl_upload_req(ioctl_upload_req), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_data(mem_data), .dirty(dirty), .busy(busy)
   );

   // Save RAM with an L-stage read pipeline; filler byte when no read issued.
   logic [7:0] ram [0:SIZE-1];
   logic [7:0] pipe [L];
   always @(posedge clk_sys) begin
      pipe[0] <= mem_rd ? ram[mem_addr] : 8'hA5;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
   end
   assign mem_data = pipe[L-1];

   // Event counters (monotonic; tasks take differences).
   int req_pulses = 0;
   int mem_rds    = 0;
   always @(posedge clk_sys) begin
      if (ioctl_upload_req) req_pulses <= req_pulses + 1;
      if (mem_rd)           mem_rds    <= mem_rds + 1;
   end

   int n_assert = 0;
   int n_fail   = 0;

   // Session-level reference model.
   logic       m_dirty     = 1'b0;
   logic       m_wr_during = 1'b0;
   logic       m_active    = 1'b0;
   logic [7:0] m_din       = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cpu_write();
      @(negedge clk_sys); cpu_wr = 1'b1;
      @(negedge clk_sys); cpu_wr = 1'b0; #1;
      m_dirty = 1'b1;
      if (m_active) m_wr_during = 1'b1;
      check("dirty_after_wr", dirty, m_dirty);
   endtask

   task automatic start_upload();
      @(negedge clk_sys); ioctl_upload = 1'b1; ioctl_index = IDX;
      m_active = 1'b1; m_wr_during = 1'b0;
   endtask

   task automatic end_upload(input string tag);
      @(negedge clk_sys); ioctl_upload = 1'b0; ioctl_index = IDX;
      repeat (3) @(negedge clk_sys);
      #1;
      m_dirty  = m_wr_during;
      m_active = 1'b0;
      check({tag, "_busy"},  busy,  1'b0);
      check({tag, "_dirty"}, dirty, m_dirty);
   endtask

   // One hps_io read; checks wait length, returned byte and RAM accesses.
   task automatic read_byte(input string tag, input logic [24:0] addr, input logic [7:0] idx);
      int  base = mem_rds;
      int  cyc;
      bit  good = (idx == IDX);
      bit  inr  = (addr < 25'(SIZE));
      @(negedge clk_sys); ioctl_rd = 1'b1; ioctl_addr = addr; ioctl_index = idx; #1;
      cyc = ioctl_wait ? 1 : 0;
      if (good && inr) check({tag, "_mem_addr"}, mem_addr, addr[12:0]);
      @(negedge clk_sys); ioctl_rd = 1'b0; #1;
      while (ioctl_wait && cyc < 20) begin
         cyc++;
         @(negedge clk_sys); #1;
      end
      if (good && inr)  m_din = ram[addr[12:0]];
      else if (good)    m_din = 8'hFF;
      check({tag, "_wait_cycles"}, cyc, (good && inr) ? L + 1 : 0);
      check({tag, "_din"},         ioctl_din, m_din);
      check({tag, "_mem_rds"},     mem_rds - base, (good && inr) ? 1 : 0);
   endtask

   task automatic save_request(input string tag);
      @(negedge clk_sys); save_req = 1'b1;
      @(negedge clk_sys); save_req = 1'b0; #1;
      check({tag, "_req_pulse"}, ioctl_upload_req, 1'b1);
      check({tag, "_busy"},      busy, 1'b1);
   endtask

   initial begin
      int base;
      int cyc;
      reset_n = 1'b0; save_req = 1'b0; cpu_wr = 1'b0; ioctl_upload = 1'b0;
      ioctl_rd = 1'b0; ioctl_index = 8'd0; ioctl_addr = '0;
      for (int i = 0; i < SIZE; i++) ram[i] = 8'($urandom);
      ram[0] = 8'h00; ram[1] = 8'h11; ram[2] = 8'h22; ram[3] = 8'h33;
      repeat (2) @(negedge clk_sys);
      reset_n = 1'b1; #1;

      // Reset state
      check("rst_din",  ioctl_din, 8'h00);
      check("rst_wait", ioctl_wait, 1'b0);
      check("rst_req",  ioctl_upload_req, 1'b0);
      check("rst_mem_rd", mem_rd, 1'b0);
      check("rst_mem_addr", mem_addr, 13'd0);
      check("rst_dirty", dirty, 1'b0);
      check("rst_busy",  busy, 1'b0);

      // Requested upload of addresses 0..3 plus random in-range addresses
      cpu_write();
      base = req_pulses;
      save_request("req1");
      @(negedge clk_sys); #1;
      check("req1_pulse_low", ioctl_upload_req, 1'b0);
      start_upload();
      for (int a = 0; a < 4; a++) read_byte("seq", 25'(a), IDX);
      for (int k = 0; k < 4; k++) read_byte("rnd", 25'($urandom_range(SIZE - 1)), IDX);
      end_upload("up1");
      check("up1_req_pulses", req_pulses - base, 1);

      // HPS-initiated upload with out-of-range reads
      base = req_pulses;
      start_upload();
      read_byte("pre_pad", 25'd2, IDX);
      read_byte("pad_8192", 25'd8192, IDX);
      read_byte("in_after_pad", 25'd1, IDX);
      read_byte("pad_max", 25'h1FFFFFF, IDX);
      read_byte("pad_rnd", 25'($urandom_range(32'h1FFFFFF, SIZE)), IDX);
      end_upload("up2");
      check("up2_no_req", req_pulses - base, 0);

      // Request with no HPS response times out
      cpu_write();
      base = req_pulses;
      save_request("tmo");
      cyc = 0;
      while (busy && cyc < 300) begin
         cyc++;
         @(negedge clk_sys); #1;
      end
      check("tmo_busy_cycles", cyc, int'(TMO));
      check("tmo_dirty", dirty, m_dirty);
      check("tmo_req_pulses", req_pulses - base, 1);

      // CPU write during an upload keeps dirty; a clean upload clears it
      start_upload();
      read_byte("wr_a", 25'($urandom_range(SIZE - 1)), IDX);
      cpu_write();
      read_byte("wr_b", 25'($urandom_range(SIZE - 1)), IDX);
      end_upload("wr_up");
      start_upload();
      read_byte("clean", 25'($urandom_range(SIZE - 1)), IDX);
      end_upload("clean_up");

      // Read on a foreign index is ignored (and ends the session)
      cpu_write();
      start_upload();
      read_byte("idx5", 25'($urandom_range(SIZE - 1)), IDX);
      read_byte("idx4", 25'($urandom_range(SIZE - 1)), 8'd4);
      end_upload("idx_up");

      // Asynchronous reset in the middle of a fetch
      cpu_write();
      start_upload();
      @(negedge clk_sys); ioctl_rd = 1'b1; ioctl_addr = 25'd3;
      @(negedge clk_sys); ioctl_rd = 1'b0; #1;
      check("fetch_wait", ioctl_wait, 1'b1);
      #1 reset_n = 1'b0; ioctl_upload = 1'b0;
      #1;
      check("arst_wait",   ioctl_wait, 1'b0);
      check("arst_mem_rd", mem_rd, 1'b0);
      check("arst_busy",   busy, 1'b0);
      check("arst_dirty",  dirty, 1'b0);
      m_dirty = 1'b0; m_active = 1'b0; m_din = 8'h00;
      @(negedge clk_sys); reset_n = 1'b1;

      // Normal operation after reset
      base = req_pulses;
      save_request("post");
      start_upload();
      read_byte("post_rd", 25'($urandom_range(SIZE - 1)), IDX);
      end_upload("post_up");
      check("post_req_pulses", req_pulses - base, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_ioctl_upload_responder
